// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory port and its arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE / DMA_LOCK)
//   F3_*        : funct3 access-size codes, shared by the memory lane/extension
//                 logic and anything that decodes an access
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DMA_LOCK = 1'b1
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick.
//   req0, req1 : request lines
//   last       : 1 = req1 was granted most recently, 0 = req0 was
//   gnt        : one-hot grant {req1, req0}, 2'b00 when nobody requests
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = {req1, req0};
        // On contention the side that was not served last wins.
        if (req0 && req1) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store unit and a
// DMA / program-loader master. CPU beats are single; DMA beats may form a
// locked burst that is force-released after BURST_MAX beats.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu_req/we/funct3/addr/wdata : CPU beat request (held until cpu_gnt)
//   cpu_gnt             : CPU beat accepted this cycle (combinational)
//   cpu_rvalid/rdata    : CPU load response, one cycle after the beat
//   dma_req/we/funct3/addr/wdata/last : DMA beat request, last ends burst
//   dma_gnt             : DMA beat accepted this cycle (combinational)
//   dma_rvalid/rdata    : DMA load response, one cycle after the beat
//   mem_wr_en/funct3/addr/wdata : memory port
//   mem_rdata           : combinational read data from memory
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | round-robin between CPU and DMA, one beat per cycle
// ST_DMA_LOCK | DMA owns the port until last beat, BURST_MAX, or abort
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_funct3,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_last,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,

    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW      = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
    localparam bit LOCK_EN = (BURST_MAX > 1);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic            last_dma;
    logic [CW-1:0]   beat_cnt;
    logic [1:0]      pick;
    logic            burst_end;

    rr_pick2 u_pick (
        .req0 (cpu_req),
        .req1 (dma_req),
        .last (last_dma),
        .gnt  (pick)
    );

    // In the lock, the beat being granted now is number beat_cnt+1.
    assign burst_end = dma_last || (beat_cnt == CW'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (LOCK_EN && dma_gnt && !dma_last) begin
                    state_nxt = ST_DMA_LOCK;
                end
            end
            ST_DMA_LOCK: begin
                // A dropped request aborts the burst without issuing a beat.
                if (!dma_req || burst_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_gnt = pick[0];
                dma_gnt = pick[1];
            end
            ST_DMA_LOCK: begin
                dma_gnt = dma_req;
            end
            default: ;
        endcase

        mem_wr_en = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
        // With no grant the port shows the CPU fields; harmless since
        // mem_wr_en is low.
        if (dma_gnt) begin
            mem_funct3 = dma_funct3;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
        end else begin
            mem_funct3 = cpu_funct3;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_dma <= 1'b1;
            beat_cnt <= '0;
        end else begin
            if (cpu_gnt) begin
                last_dma <= 1'b0;
            end else if (dma_gnt) begin
                last_dma <= 1'b1;
            end
            if (dma_gnt) begin
                beat_cnt <= (state == ST_IDLE) ? CW'(1) : beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [2:0]    cpu_funct3;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [2:0]    dma_funct3;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_wr_en;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_last(dma_last),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- behavioural byte memory (256 bytes) ----------------
    logic [7:0] mem [256];
    logic       mem_clr;
    logic [7:0] wa, wa1, wa2, wa3;
    assign wa  = mem_addr[7:0];
    assign wa1 = wa + 8'd1;
    assign wa2 = wa + 8'd2;
    assign wa3 = wa + 8'd3;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_wr_en) begin
            case (mem_funct3)
                F3_B, F3_BU: mem[wa] <= mem_wdata[7:0];
                F3_H, F3_HU: begin
                    mem[wa]  <= mem_wdata[7:0];
                    mem[wa1] <= mem_wdata[15:8];
                end
                default: begin
                    mem[wa]  <= mem_wdata[7:0];
                    mem[wa1] <= mem_wdata[15:8];
                    mem[wa2] <= mem_wdata[23:16];
                    mem[wa3] <= mem_wdata[31:24];
                end
            endcase
        end
    end

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [7:0] b0,
                                        input logic [7:0] b1, input logic [7:0] b2,
                                        input logic [7:0] b3);
        case (f3)
            F3_B:    return {{24{b0[7]}}, b0};
            F3_BU:   return {24'h0, b0};
            F3_H:    return {{16{b1[7]}}, b1, b0};
            F3_HU:   return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    logic [7:0] rb0, rb1, rb2, rb3;
    assign rb0 = mem[wa];
    assign rb1 = mem[wa1];
    assign rb2 = mem[wa2];
    assign rb3 = mem[wa3];
    assign mem_rdata = ext(mem_funct3, rb0, rb1, rb2, rb3);

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] x;
        x = a[7:0];
        return ext(f3, mem[x], mem[x + 8'd1], mem[x + 8'd2], mem[x + 8'd3]);
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: who owns the port, how many locked beats so far,
    // who was served last, and what each response register should hold.
    bit          m_locked, m_last_dma, m_gc, m_gd, m_crv, m_drv;
    int          m_beats;
    logic [31:0] m_crd, m_drd, m_ld;

    task automatic model_reset();
        m_locked = 0; m_last_dma = 1; m_beats = 0;
        m_crv = 0; m_drv = 0; m_crd = '0; m_drd = '0;
    endtask

    task automatic model_check();
        if (m_locked) begin
            m_gc = 0;
            m_gd = dma_req;
        end else if (cpu_req && dma_req) begin
            m_gc = m_last_dma;
            m_gd = !m_last_dma;
        end else begin
            m_gc = cpu_req;
            m_gd = dma_req;
        end
        chk("m_cpu_gnt", {31'b0, cpu_gnt}, {31'b0, m_gc});
        chk("m_dma_gnt", {31'b0, dma_gnt}, {31'b0, m_gd});
        chk("m_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_crv});
        chk("m_dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_drv});
        chk("m_cpu_rdata", cpu_rdata, m_crd);
        chk("m_dma_rdata", dma_rdata, m_drd);
        if (m_gd) begin
            chk("m_mem_wr_en", {31'b0, mem_wr_en}, {31'b0, dma_we});
            chk("m_mem_addr", mem_addr, dma_addr);
            chk("m_mem_wdata", mem_wdata, dma_wdata);
            chk("m_mem_funct3", {29'b0, mem_funct3}, {29'b0, dma_funct3});
            m_ld = exp_read(dma_addr, dma_funct3);
        end else if (m_gc) begin
            chk("m_mem_wr_en", {31'b0, mem_wr_en}, {31'b0, cpu_we});
            chk("m_mem_addr", mem_addr, cpu_addr);
            chk("m_mem_wdata", mem_wdata, cpu_wdata);
            chk("m_mem_funct3", {29'b0, mem_funct3}, {29'b0, cpu_funct3});
            m_ld = exp_read(cpu_addr, cpu_funct3);
        end else begin
            chk("m_mem_wr_en_idle", {31'b0, mem_wr_en}, 32'd0);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_crv = m_gc && !cpu_we;
        m_drv = m_gd && !dma_we;
        if (m_crv) m_crd = m_ld;
        if (m_drv) m_drd = m_ld;
        if (m_gc) m_last_dma = 0;
        if (m_gd) begin
            m_last_dma = 1;
            if (!m_locked) begin
                m_beats  = 1;
                m_locked = !dma_last && (BM > 1);
            end else begin
                m_beats++;
                if (dma_last || m_beats == BM) m_locked = 0;
            end
        end else if (m_locked) begin
            m_locked = 0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst;
        bit          creq, cwe;
        logic [2:0]  cf3;
        logic [31:0] caddr, cwd;
        bit          dreq, dwe, dlast;
        logic [2:0]  df3;
        logic [31:0] daddr, dwd;
        bit          ecg, edg, ecrv, edrv;
        logic [31:0] ecrd, edrd;
    } vec_t;

    function automatic vec_t row(bit rst, bit creq, bit cwe, logic [2:0] cf3, logic [31:0] caddr,
                                 logic [31:0] cwd, bit dreq, bit dwe, bit dlast, logic [2:0] df3,
                                 logic [31:0] daddr, logic [31:0] dwd, bit ecg, bit edg,
                                 bit ecrv, bit edrv, logic [31:0] ecrd, logic [31:0] edrd);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.cf3 = cf3; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlast = dlast; v.df3 = df3; v.daddr = daddr; v.dwd = dwd;
        v.ecg = ecg; v.edg = edg; v.ecrv = ecrv; v.edrv = edrv; v.ecrd = ecrd; v.edrd = edrd;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic drive(input vec_t v);
        rst_n = v.rst;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_funct3 = v.cf3; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dma_req = v.dreq; dma_we = v.dwe; dma_last = v.dlast; dma_funct3 = v.df3;
        dma_addr = v.daddr; dma_wdata = v.dwd;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] V1 = 32'h11111111;
    localparam logic [31:0] V2 = 32'h22222222;
    localparam logic [31:0] V3 = 32'h33333333;
    localparam logic [31:0] V4 = 32'h44444444;

    // random-phase pending request bookkeeping
    bit c_hold, d_hold;

    function automatic logic [2:0] rnd_f3();
        case ($urandom_range(0, 4))
            0: return F3_B;
            1: return F3_H;
            2: return F3_BU;
            3: return F3_HU;
            default: return F3_W;
        endcase
    endfunction

    initial begin
        vec_t v;
        mem_clr = 1'b1;
        v = row(0, 0,0,F3_W,0,0, 0,0,0,F3_W,0,0, 0,0,0,0, 0,0);
        drive(v);
        model_reset();
        @(negedge clk);
        advance();
        advance();
        mem_clr = 1'b0;

        //            rst creq cwe cf3  caddr  cwd        dreq dwe dlast df3 daddr  dwd     cg dg crv drv crd  drd
        vecs.push_back(row(0, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,0,0, 0,0));
        vecs.push_back(row(1, 1,1,F3_W,'h10,DB,        0,0,0,F3_W,0,0,        1,0,0,0, 0,0));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         0,0,0,F3_W,0,0,        1,0,0,0, 0,0));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,1,0, DB,0));
        vecs.push_back(row(0, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,0,0, DB,0));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,1,F3_W,'h10,0,     1,0,0,0, 0,0));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,1,F3_W,'h10,0,     0,1,1,0, DB,0));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,1,F3_W,'h10,0,     1,0,0,1, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,1,F3_W,'h10,0,     0,1,1,0, DB,DB));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,0,1, DB,DB));
        // 4-beat locked store burst with the CPU waiting
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,1,0,F3_W,'h20,V1,    1,0,0,0, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,1,0,F3_W,'h20,V1,    0,1,1,0, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,1,0,F3_W,'h24,V2,    0,1,0,0, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,1,0,F3_W,'h28,V3,    0,1,0,0, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,1,1,F3_W,'h2C,V4,    0,1,0,0, DB,DB));
        vecs.push_back(row(1, 1,0,F3_W,'h2C,0,         1,0,1,F3_W,'h20,0,     1,0,0,0, DB,DB));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            1,0,1,F3_W,'h20,0,     0,1,1,0, V4,DB));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,0,1, V4,V1));
        // unterminated burst: forced release after BM beats
        vecs.push_back(row(1, 0,0,F3_W,0,0,            1,0,0,F3_W,'h20,0,     0,1,0,0, V4,V1));
        vecs.push_back(row(1, 1,0,F3_W,'h28,0,         1,0,0,F3_W,'h24,0,     0,1,0,1, V4,V1));
        for (int i = 0; i < 6; i++)
            vecs.push_back(row(1, 1,0,F3_W,'h28,0,     1,0,0,F3_W,'h24,0,     0,1,0,1, V4,V2));
        vecs.push_back(row(1, 1,0,F3_W,'h28,0,         1,0,0,F3_W,'h24,0,     1,0,0,1, V4,V2));
        vecs.push_back(row(1, 1,0,F3_W,'h28,0,         1,0,0,F3_W,'h24,0,     0,1,1,0, V3,V2));
        // DMA drops its request inside the lock: abort, no beat
        vecs.push_back(row(1, 1,0,F3_W,'h28,0,         0,0,0,F3_W,0,0,        0,0,0,1, V3,V2));
        vecs.push_back(row(1, 1,0,F3_W,'h28,0,         0,0,0,F3_W,0,0,        1,0,0,0, V3,V2));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,1,0, V3,V2));
        // byte store then signed / unsigned byte loads
        vecs.push_back(row(1, 0,0,F3_W,0,0,            1,1,1,F3_B,'h31,'h80,  0,1,0,0, V3,V2));
        vecs.push_back(row(1, 1,0,F3_B,'h31,0,         0,0,0,F3_W,0,0,        1,0,0,0, V3,V2));
        vecs.push_back(row(1, 1,0,F3_BU,'h31,0,        0,0,0,F3_W,0,0,        1,0,1,0, 32'hFFFFFF80,V2));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,1,0, 32'h80,V2));
        // reset during beat 3 of a locked burst
        vecs.push_back(row(1, 0,0,F3_W,0,0,            1,1,0,F3_W,'h40,'h55,  0,1,0,0, 32'h80,V2));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,0,F3_W,'h20,0,     0,1,0,0, 32'h80,V2));
        vecs.push_back(row(0, 1,0,F3_W,'h10,0,         1,0,0,F3_W,'h28,0,     0,1,0,1, 32'h80,V1));
        vecs.push_back(row(1, 1,0,F3_W,'h10,0,         1,0,1,F3_W,'h20,0,     1,0,0,0, 0,0));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            1,0,1,F3_W,'h20,0,     0,1,1,0, DB,0));
        vecs.push_back(row(1, 0,0,F3_W,0,0,            0,0,0,F3_W,0,0,        0,0,0,1, DB,V1));

        foreach (vecs[i]) begin
            string tag;
            drive(vecs[i]);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, "_cpu_gnt"},    {31'b0, cpu_gnt},    {31'b0, vecs[i].ecg});
            chk({tag, "_dma_gnt"},    {31'b0, dma_gnt},    {31'b0, vecs[i].edg});
            chk({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, {31'b0, vecs[i].ecrv});
            chk({tag, "_dma_rvalid"}, {31'b0, dma_rvalid}, {31'b0, vecs[i].edrv});
            chk({tag, "_cpu_rdata"},  cpu_rdata,           vecs[i].ecrd);
            chk({tag, "_dma_rdata"},  dma_rdata,           vecs[i].edrd);
            model_check();
            advance();
        end

        // ---------------- randomized traffic vs. model ----------------
        c_hold = 0;
        d_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!c_hold) begin
                cpu_req    = ($urandom_range(0, 99) < 60);
                cpu_we     = $urandom_range(0, 1);
                cpu_funct3 = rnd_f3();
                cpu_addr   = $urandom;
                cpu_wdata  = $urandom;
            end
            if (!d_hold) begin
                dma_req    = ($urandom_range(0, 99) < 70);
                dma_we     = $urandom_range(0, 1);
                dma_funct3 = rnd_f3();
                dma_addr   = $urandom;
                dma_wdata  = $urandom;
                dma_last   = ($urandom_range(0, 3) == 0);
            end
            #1;
            model_check();
            c_hold = cpu_req && !cpu_gnt && rst_n;
            d_hold = dma_req && !dma_gnt && rst_n;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
